// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - command/result bundle between EX stage and the iterative mul/div unit
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] md_a;
  logic [WIDTH-1:0] md_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, md_a, md_b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, md_op, md_a, md_b, flush, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mdu_iter_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_is_div;
  logic               r_dz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_opd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_idle_ok;
  logic               w_accept;
  logic               w_is_div;
  logic               w_signed;
  logic               w_dz;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH+1:0]   w_div_diff;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH-1:0]   w_div_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_remv;

  // A divide-by-zero DONE still counts as busy, so it cannot take a new start or MTHI/MTLO
  assign w_idle_ok = (r_state == S_IDLE) || ((r_state == S_DONE) && !r_dz);
  assign w_accept  = bus.start && w_idle_ok && !bus.flush;
  assign w_is_div  = bus.md_op[1];
  assign w_signed  = ~bus.md_op[0];
  assign w_dz      = w_is_div && (bus.md_b == '0);
  assign w_mag_a   = (w_signed && bus.md_a[WIDTH-1]) ? -bus.md_a : bus.md_a;
  assign w_mag_b   = (w_signed && bus.md_b[WIDTH-1]) ? -bus.md_b : bus.md_b;

  // Shift-add: add the multiplicand into the upper half when the current multiplier LSB is set
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opd : '0)};

  // Restoring divide: dividend bits shift out of the quotient register into the remainder
  assign w_div_diff = {r_rem, r_acc[WIDTH-1]} - {2'b00, r_opd};
  assign w_div_rem  = w_div_diff[WIDTH+1] ? {r_rem[WIDTH-1:0], r_acc[WIDTH-1]} : w_div_diff[WIDTH:0];
  assign w_div_q    = {r_acc[WIDTH-2:0], ~w_div_diff[WIDTH+1]};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remv = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (w_accept) w_next = w_dz ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (bus.flush)          w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_FIX;
      end
      S_FIX:   w_next = bus.flush ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_opd    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], w_div_q};
            r_rem <= w_div_rem;
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            if (r_is_div) begin
              r_hi <= w_remv;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          if (w_accept) begin
            r_is_div <= w_is_div;
            r_dz     <= w_dz;
            r_neg_q  <= w_signed && (bus.md_a[WIDTH-1] ^ bus.md_b[WIDTH-1]);
            r_neg_r  <= w_signed && bus.md_a[WIDTH-1];
            r_cnt    <= CW'(WIDTH-1);
            r_rem    <= '0;
            if (w_is_div) begin
              r_opd <= w_mag_b;
              r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            end else begin
              r_opd <= w_mag_a;
              r_acc <= {{WIDTH{1'b0}}, w_mag_b};
            end
          end else if (w_idle_ok) begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
      endcase
    end
  end

  assign bus.busy     = ~w_idle_ok;
  assign bus.done     = (r_state == S_DONE);
  assign bus.div_zero = (r_state == S_DONE) && r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule
